// File: rtl/nv_nvdla_sync_pkg.sv
// nv_nvdla_sync_pkg: shared constants and elaboration helpers for the strict synchroniser family
package nv_nvdla_sync_pkg;
    localparam int SYNC_MIN_STAGES = 2;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int clog2(input int v);
        int w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

    function automatic bit stages_ok(input int stages);
        return stages >= SYNC_MIN_STAGES;
    endfunction
endpackage

// File: rtl/nv_nvdla_sync_filter_chn.sv
// nv_nvdla_sync_filter_chn: one channel of flop chain, stability filter, edge pulses and sticky event
module nv_nvdla_sync_filter_chn
    import nv_nvdla_sync_pkg::*;
#(
    parameter int   STAGES   = 3,
    parameter int   FILT_CYC = 0,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic o_clk,
    input  logic o_rst,
    input  logic sync_i,
    input  logic evt_clr_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);
    localparam int CW = clog2(FILT_CYC + 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage;
    logic [CW-1:0] cnt;
    logic s;
    logic acc;

    assign s   = stage[STAGES-1];
    assign acc = (s != sync_o) && (cnt == CW'(FILT_CYC));

    // Counter restarts whenever s agrees with the output or a change is accepted
    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            stage  <= {STAGES{RST_VAL}};
            cnt    <= '0;
            sync_o <= RST_VAL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            evt_o  <= 1'b0;
        end else begin
            stage  <= {stage[STAGES-2:0], sync_i};
            cnt    <= (s == sync_o || acc) ? '0 : cnt + CW'(1);
            sync_o <= acc ? s : sync_o;
            rise_o <= acc & s;
            fall_o <= acc & ~s;
            evt_o  <= acc | (evt_o & ~evt_clr_i);
        end
    end
endmodule

// File: rtl/nv_nvdla_sync_filter.sv
// nv_nvdla_sync_filter: WIDTH independent filtered strict synchronisers into the o_clk domain
module nv_nvdla_sync_filter
    import nv_nvdla_sync_pkg::*;
#(
    parameter int   WIDTH    = 1,
    parameter int   STAGES   = 3,
    parameter int   FILT_CYC = 0,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic             o_clk,
    input  logic             o_rst,
    input  logic [WIDTH-1:0] sync_i,
    input  logic [WIDTH-1:0] evt_clr_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] evt_o
);
    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("nv_nvdla_sync_filter: STAGES must be at least 2");
    end

    // Channels are deliberately uncoupled; multi-bit buses must be Gray-coded or quasi-static
    for (genvar g = 0; g < WIDTH; g++) begin : g_chn
        nv_nvdla_sync_filter_chn #(
            .STAGES  (STAGES),
            .FILT_CYC(FILT_CYC),
            .RST_VAL (RST_VAL)
        ) u_chn (
            .o_clk    (o_clk),
            .o_rst    (o_rst),
            .sync_i   (sync_i[g]),
            .evt_clr_i(evt_clr_i[g]),
            .sync_o   (sync_o[g]),
            .rise_o   (rise_o[g]),
            .fall_o   (fall_o[g]),
            .evt_o    (evt_o[g])
        );
    end
endmodule

// File: tb/tb_nv_nvdla_sync_filter.sv
// tb_nv_nvdla_sync_filter: directed checks of latency, filtering, sticky events, independence and reset
module tb_nv_nvdla_sync_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: WIDTH=8 STAGES=3 FILT=0 RST_VAL=0
    logic       rst0 = 1'b1;
    logic [7:0] in0 = '0, clr0 = '0, so0, r0, f0, e0;
    // u1: WIDTH=1 STAGES=3 FILT=3 RST_VAL=0
    logic       rst1 = 1'b1;
    logic       in1 = 1'b0, clr1 = 1'b0, so1, r1, f1, e1;
    // u2: WIDTH=2 STAGES=2 FILT=5 RST_VAL=1
    logic       rst2 = 1'b1;
    logic [1:0] in2 = '0, clr2 = '0, so2, r2, f2, e2;

    nv_nvdla_sync_filter #(.WIDTH(8), .STAGES(3), .FILT_CYC(0), .RST_VAL(1'b0)) u0 (
        .o_clk(clk), .o_rst(rst0), .sync_i(in0), .evt_clr_i(clr0),
        .sync_o(so0), .rise_o(r0), .fall_o(f0), .evt_o(e0));
    nv_nvdla_sync_filter #(.WIDTH(1), .STAGES(3), .FILT_CYC(3), .RST_VAL(1'b0)) u1 (
        .o_clk(clk), .o_rst(rst1), .sync_i(in1), .evt_clr_i(clr1),
        .sync_o(so1), .rise_o(r1), .fall_o(f1), .evt_o(e1));
    nv_nvdla_sync_filter #(.WIDTH(2), .STAGES(2), .FILT_CYC(5), .RST_VAL(1'b1)) u2 (
        .o_clk(clk), .o_rst(rst2), .sync_i(in2), .evt_clr_i(clr2),
        .sync_o(so2), .rise_o(r2), .fall_o(f2), .evt_o(e2));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with u2 inputs toggling
        for (int i = 0; i < 3; i++) begin
            step(1);
            in2 = ~in2;
            chk("rst_so2", {6'd0, so2}, 8'h03);
            chk("rst_pulse2", {4'd0, r2, f2}, 8'h00);
            chk("rst_evt2", {6'd0, e2}, 8'h00);
        end
        chk("rst_so0", so0, 8'h00);
        chk("rst_evt0", e0, 8'h00);
        chk("rst_so1", {7'd0, so1}, 8'h00);
        in2 = 2'b11;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        step(5);
        chk("idle_so2", {6'd0, so2}, 8'h03);
        chk("idle_evt2", {6'd0, e2}, 8'h00);

        // Latency: bit 0 rises, visible at edge 4
        in0 = 8'h01;
        step(3);
        chk("lat_e3_so", so0, 8'h00);
        chk("lat_e3_rise", r0, 8'h00);
        step(1);
        chk("lat_e4_so", so0, 8'h01);
        chk("lat_e4_rise", r0, 8'h01);
        chk("lat_e4_fall", f0, 8'h00);
        chk("lat_e4_evt", e0, 8'h01);
        step(1);
        chk("lat_e5_rise", r0, 8'h00);
        chk("lat_e5_evt", e0, 8'h01);

        // Independence: bit 7 rises, then bit 0 falls
        in0 = 8'h81;
        step(4);
        chk("ind_so_b7", so0, 8'h81);
        chk("ind_rise_b7", r0, 8'h80);
        chk("ind_evt_b7", e0, 8'h81);
        in0 = 8'h80;
        step(4);
        chk("ind_so_b0", so0, 8'h80);
        chk("ind_fall_b0", f0, 8'h01);
        chk("ind_rise_none", r0, 8'h00);

        // Sticky: clear coincides with accepted fall of bit 7, then clears next cycle
        in0 = 8'h00;
        step(3);
        clr0 = 8'h80;
        step(1);
        chk("stk_fall", f0, 8'h80);
        chk("stk_set_wins", e0, 8'h81);
        step(1);
        chk("stk_cleared", e0, 8'h01);
        clr0 = 8'hff;
        step(1);
        clr0 = 8'h00;
        chk("stk_all_clr", e0, 8'h00);
        chk("stk_so", so0, 8'h00);

        // Filter: 3-cycle glitch rejected
        in1 = 1'b1;
        step(3);
        in1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("flt_glitch_so", {7'd0, so1}, 8'h00);
            chk("flt_glitch_pulse", {6'd0, r1, f1}, 8'h00);
        end
        // Filter: held level accepted at edge STAGES+4
        in1 = 1'b1;
        step(6);
        chk("flt_e6_so", {7'd0, so1}, 8'h00);
        step(1);
        chk("flt_e7_so", {7'd0, so1}, 8'h01);
        chk("flt_e7_rise", {7'd0, r1}, 8'h01);
        chk("flt_e7_evt", {7'd0, e1}, 8'h01);
        step(1);
        chk("flt_e8_rise", {7'd0, r1}, 8'h00);

        // Reset mid-filter: counter at 3 when reset hits
        in2 = 2'b00;
        step(5);
        chk("mid_pre_so", {6'd0, so2}, 8'h03);
        rst2 = 1'b1;
        #1;
        chk("mid_rst_so", {6'd0, so2}, 8'h03);
        step(2);
        rst2 = 1'b0;
        step(7);
        chk("mid_e7_so", {6'd0, so2}, 8'h03);
        chk("mid_e7_fall", {6'd0, f2}, 8'h00);
        step(1);
        chk("mid_e8_so", {6'd0, so2}, 8'h00);
        chk("mid_e8_fall", {6'd0, f2}, 8'h03);
        chk("mid_e8_rise", {6'd0, r2}, 8'h00);
        chk("mid_e8_evt", {6'd0, e2}, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
